// File: rtl/cordic_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, producing cos/sin
// of a Q2.14 angle with the CORDIC gain pre-compensated in the initial x.
module cordic_iter #(
   parameter int WIDTH      = 16,
   parameter int ITERATIONS = 14,
   parameter int ITER_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] angle,
   output logic                    busy,
   output logic                    valid,
   output logic signed [WIDTH-1:0] cos_out,
   output logic signed [WIDTH-1:0] sin_out
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [WIDTH-1:0] ZMAX  = WIDTH'(25736);
   localparam logic signed [WIDTH-1:0] ZMIN  = -ZMAX;
   localparam logic signed [WIDTH-1:0] XINIT = WIDTH'(9949);
   localparam logic [ITER_WIDTH-1:0]   LAST  = ITER_WIDTH'(ITERATIONS - 1);

   function automatic logic signed [WIDTH-1:0] atan_lut(input logic [ITER_WIDTH-1:0] i);
      case (int'(i))
         0:       atan_lut = WIDTH'(12868);
         1:       atan_lut = WIDTH'(7596);
         2:       atan_lut = WIDTH'(4014);
         3:       atan_lut = WIDTH'(2037);
         4:       atan_lut = WIDTH'(1023);
         5:       atan_lut = WIDTH'(512);
         6:       atan_lut = WIDTH'(256);
         7:       atan_lut = WIDTH'(128);
         8:       atan_lut = WIDTH'(64);
         9:       atan_lut = WIDTH'(32);
         10:      atan_lut = WIDTH'(16);
         11:      atan_lut = WIDTH'(8);
         12:      atan_lut = WIDTH'(4);
         13:      atan_lut = WIDTH'(2);
         14:      atan_lut = WIDTH'(1);
         default: atan_lut = '0;
      endcase
   endfunction

   state_t                  state;
   logic signed [WIDTH-1:0] x, y, z;
   logic [ITER_WIDTH-1:0]   iter;

   logic signed [WIDTH-1:0] x_sh, y_sh, x_nx, y_nx, z_nx, z_init, atan_i;

   always_comb begin
      if (angle > ZMAX)      z_init = ZMAX;
      else if (angle < ZMIN) z_init = ZMIN;
      else                   z_init = angle;
   end

   // d = +1 when z is non-negative, i.e. rotate towards driving z to zero
   always_comb begin
      x_sh   = x >>> iter;
      y_sh   = y >>> iter;
      atan_i = atan_lut(iter);
      if (!z[WIDTH-1]) begin
         x_nx = x - y_sh;
         y_nx = y + x_sh;
         z_nx = z - atan_i;
      end else begin
         x_nx = x + y_sh;
         y_nx = y - x_sh;
         z_nx = z + atan_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         valid   <= 1'b0;
         cos_out <= '0;
         sin_out <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         iter    <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x     <= XINIT;
                  y     <= '0;
                  z     <= z_init;
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               x <= x_nx;
               y <= y_nx;
               z <= z_nx;
               if (iter == LAST) begin
                  cos_out <= x_nx;
                  sin_out <= y_nx;
                  valid   <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  iter <= iter + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: directed test-plan points, random angles
// against an integer reference model, start-ignore, held-start and async reset.
module tb_cordic_iter;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] angle = '0;
   logic               busy, valid;
   logic signed [15:0] cos_out, sin_out;

   int nchk  = 0;
   int nfail = 0;

   localparam int ATAN_T [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                                  64, 32, 16, 8, 4, 2, 1, 0};

   cordic_iter #(.WIDTH(16), .ITERATIONS(14), .ITER_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .angle(angle),
      .busy(busy), .valid(valid), .cos_out(cos_out), .sin_out(sin_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Plain integer CORDIC: saturate, rotate 14 times with floor shifts.
   task automatic model(input int a, output int c, output int s);
      int x, y, z, xo;
      z = (a > 25736) ? 25736 : (a < -25736) ? -25736 : a;
      x = 9949;
      y = 0;
      for (int i = 0; i < 14; i++) begin
         xo = x;
         if (z >= 0) begin
            x = x - (y >>> i); y = y + (xo >>> i); z = z - ATAN_T[i];
         end else begin
            x = x + (y >>> i); y = y - (xo >>> i); z = z + ATAN_T[i];
         end
      end
      c = x;
      s = y;
   endtask

   function automatic int near(input int got, input int exp);
      return ((got - exp) <= 4 && (exp - got) <= 4) ? 1 : 0;
   endfunction

   // Accept a conversion at E0, scramble angle afterwards, wait for valid.
   task automatic convert(input logic signed [15:0] a, output int lat);
      int c, s;
      @(negedge clk);
      start = 1'b1;
      angle = a;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      angle = 16'($urandom);
      chk("busy_after_start", int'(busy), 1);
      lat = 0;
      while (!valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", lat, 14);
      model(int'(a), c, s);
      chk("cos_model", int'(cos_out), c);
      chk("sin_model", int'(sin_out), s);
      chk("busy_in_valid", int'(busy), 0);
      @(posedge clk);
      @(negedge clk);
      chk("valid_one_cycle", int'(valid), 0);
      chk("cos_hold", int'(cos_out), c);
   endtask

   initial begin
      int lat, c, s, bad, n;
      int vq[$];

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_cos", int'(cos_out), 0);
      chk("rst_sin", int'(sin_out), 0);
      rst = 1'b1;

      // directed points from the test plan
      convert(16'sd0, lat);
      chk("a0_cos", near(int'(cos_out), 16384), 1);
      chk("a0_sin", near(int'(sin_out), 0), 1);
      convert(16'sd12868, lat);
      chk("pi4_cos", near(int'(cos_out), 11585), 1);
      chk("pi4_sin", near(int'(sin_out), 11585), 1);
      convert(-16'sd12868, lat);
      chk("npi4_cos", near(int'(cos_out), 11585), 1);
      chk("npi4_sin", near(int'(sin_out), -11585), 1);
      convert(16'sd25736, lat);
      chk("pi2_cos", near(int'(cos_out), 0), 1);
      chk("pi2_sin", near(int'(sin_out), 16384), 1);
      convert(16'sd30000, lat);
      chk("sat_hi_cos", near(int'(cos_out), 0), 1);
      chk("sat_hi_sin", near(int'(sin_out), 16384), 1);
      convert(-16'sd32768, lat);
      chk("sat_lo_sin", near(int'(sin_out), -16384), 1);

      // random angles across the whole 16-bit range, including saturation
      repeat (20) convert(16'($urandom), lat);

      // start pulses at cycles 3 and 10 of a run must be ignored
      @(negedge clk);
      start = 1'b1;
      angle = 16'sd5000;
      @(posedge clk);
      bad = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k < 14) begin
            if (!busy || valid) bad++;
         end
         start = (k == 3 || k == 10);
         angle = (k == 3 || k == 10) ? -16'sd9000 : 16'sd5000;
         @(posedge clk);
      end
      @(negedge clk);
      chk("ignore_busy_held", bad, 0);
      chk("ignore_valid", int'(valid), 1);
      model(5000, c, s);
      chk("ignore_cos", int'(cos_out), c);
      chk("ignore_sin", int'(sin_out), s);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ignore_no_requeue", int'(busy), 0);

      // start held high: back-to-back conversions
      start = 1'b1;
      angle = 16'sd0;
      @(posedge clk);
      bad = 0;
      for (int k = 1; k <= 46; k++) begin
         @(posedge clk);
         #1;
         if (valid) vq.push_back(k);
         if (busy == valid) bad++;
      end
      @(negedge clk);
      start = 1'b0;
      chk("held_busy_vs_valid", bad, 0);
      chk("held_count", vq.size(), 3);
      if (vq.size() == 3) begin
         chk("held_v0", vq[0], 14);
         chk("held_v1", vq[1], 29);
         chk("held_v2", vq[2], 44);
      end
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("held_drain", int'(busy), 0);

      // asynchronous reset mid-run, at iteration 7
      @(negedge clk);
      start = 1'b1;
      angle = 16'sd7000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_valid", int'(valid), 0);
      chk("arst_cos", int'(cos_out), 0);
      chk("arst_sin", int'(sin_out), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (valid || busy) bad++;
      end
      chk("arst_no_valid", bad, 0);
      convert(16'sd0, lat);
      chk("arst_recover_cos", near(int'(cos_out), 16384), 1);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
